// File: rtl/pivot_selector.sv
// ============================================================================
// Module   : pivot_selector
// Purpose  : Reads a 4x4 signed covariance matrix row by row and selects the
//            Jacobi pivot pair (p,q), or a round-robin pair when the macro
//            PIVOT_CYCLIC_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pivot_selector #(
    parameter logic [7:0] THRESH   = 8'd2,
    parameter int         READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        ena_cov,
    output logic [1:0]  addra_cov,
    input  logic [31:0] douta_cov,
    output logic [1:0]  p,
    output logic [1:0]  q,
    output logic [7:0]  a_pp,
    output logic [7:0]  a_qq,
    output logic [7:0]  a_pq,
    output logic        pivot_valid,
    output logic        converged,
    output logic        busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ    = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_COMPARE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] C_LAST_PAIR = 3'd5;

    generate
        if (READ_LAT != 1) begin : g_lat_check
            $error("pivot_selector: only READ_LAT == 1 is supported");
        end
    endgenerate

    function automatic logic [1:0] f_pair_p(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: f_pair_p = 2'd0;
            3'd3, 3'd4:       f_pair_p = 2'd1;
            default:          f_pair_p = 2'd2;
        endcase
    endfunction

    function automatic logic [1:0] f_pair_q(input logic [2:0] idx);
        case (idx)
            3'd0:       f_pair_q = 2'd1;
            3'd1, 3'd3: f_pair_q = 2'd2;
            default:    f_pair_q = 2'd3;
        endcase
    endfunction

    // Column 0 lives in the most significant byte of the row word.
    function automatic logic [7:0] f_elem(input logic [31:0] row, input logic [1:0] col);
        case (col)
            2'd0:    f_elem = row[31:24];
            2'd1:    f_elem = row[23:16];
            2'd2:    f_elem = row[15:8];
            default: f_elem = row[7:0];
        endcase
    endfunction

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic        r_ena;
    logic [1:0]  r_addr;
    logic        r_rd_vld;
    logic [1:0]  r_rd_addr;
    logic [31:0] r_rows [4];
    logic [2:0]  r_cnt;
    logic [7:0]  r_max_mag;
    logic [2:0]  r_max_idx;
    logic [1:0]  r_p, r_q;
    logic [7:0]  r_a_pp, r_a_qq, r_a_pq;
    logic        r_conv;

    logic [7:0]  w_elem, w_mag, w_fin_mag;
    logic [2:0]  w_fin_idx, w_sel_idx;
    logic [1:0]  w_sel_p, w_sel_q;
    logic        w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_READ;
            S_READ:    if (r_addr == 2'd3) w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_COMPARE;
            S_COMPARE: if (r_cnt == C_LAST_PAIR) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (r_state != S_IDLE);
        pivot_valid = (r_state == S_DONE);
    end

    assign w_elem    = f_elem(r_rows[f_pair_p(r_cnt)], f_pair_q(r_cnt));
    assign w_mag     = w_elem[7] ? (~w_elem + 8'd1) : w_elem;
    assign w_fin_mag = (w_mag > r_max_mag) ? w_mag : r_max_mag;
    assign w_fin_idx = (w_mag > r_max_mag) ? r_cnt : r_max_idx;
    assign w_last    = (r_state == S_COMPARE) && (r_cnt == C_LAST_PAIR);

`ifdef PIVOT_CYCLIC_EN
    logic [2:0] r_rr_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_rr_idx <= 3'd0;
        else if (w_last) r_rr_idx <= (r_rr_idx == C_LAST_PAIR) ? 3'd0 : r_rr_idx + 3'd1;
    end

    assign w_sel_idx = r_rr_idx;

    // The max-search index only drives converged-independent selection otherwise.
    logic w_unused_idx;
    assign w_unused_idx = ^w_fin_idx;
`else
    assign w_sel_idx = w_fin_idx;
`endif

    assign w_sel_p = f_pair_p(w_sel_idx);
    assign w_sel_q = f_pair_q(w_sel_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ena     <= 1'b0;
            r_addr    <= 2'd0;
            r_rd_vld  <= 1'b0;
            r_rd_addr <= 2'd0;
            r_cnt     <= 3'd0;
            r_max_mag <= 8'd0;
            r_max_idx <= 3'd0;
            r_p       <= 2'd0;
            r_q       <= 2'd0;
            r_a_pp    <= 8'd0;
            r_a_qq    <= 8'd0;
            r_a_pq    <= 8'd0;
            r_conv    <= 1'b0;
            for (int i = 0; i < 4; i++) r_rows[i] <= 32'd0;
        end else begin
            // One-cycle delayed copy of the read request marks when douta is valid.
            r_rd_vld  <= r_ena;
            r_rd_addr <= r_addr;
            if (r_rd_vld) r_rows[r_rd_addr] <= douta_cov;

            if (r_state == S_IDLE && start) begin
                r_ena  <= 1'b1;
                r_addr <= 2'd0;
            end else if (r_state == S_READ) begin
                if (r_addr == 2'd3) begin
                    r_ena  <= 1'b0;
                    r_addr <= 2'd0;
                end else begin
                    r_addr <= r_addr + 2'd1;
                end
            end

            if (r_state == S_COMPARE) r_cnt <= r_cnt + 3'd1;
            else                      r_cnt <= 3'd0;

            if (r_state == S_CAPTURE) begin
                r_max_mag <= 8'd0;
                r_max_idx <= 3'd0;
            end else if (r_state == S_COMPARE) begin
                r_max_mag <= w_fin_mag;
                r_max_idx <= w_fin_idx;
            end

            if (w_last) begin
                r_p    <= w_sel_p;
                r_q    <= w_sel_q;
                r_a_pp <= f_elem(r_rows[w_sel_p], w_sel_p);
                r_a_qq <= f_elem(r_rows[w_sel_q], w_sel_q);
                r_a_pq <= f_elem(r_rows[w_sel_p], w_sel_q);
                r_conv <= (w_fin_mag < THRESH);
            end
        end
    end

    assign ena_cov   = r_ena;
    assign addra_cov = r_addr;
    assign p         = r_p;
    assign q         = r_q;
    assign a_pp      = r_a_pp;
    assign a_qq      = r_a_qq;
    assign a_pq      = r_a_pq;
    assign converged = r_conv;

endmodule

`default_nettype wire

// File: tb/tb_pivot_selector.sv
// ============================================================================
// Module   : tb_pivot_selector
// Purpose  : Directed self-checking bench for pivot_selector with a 1-cycle
//            BRAM model; expected results are hand-computed per matrix.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pivot_selector;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ena_cov;
    logic [1:0]  addra_cov;
    logic [31:0] douta_cov = 32'd0;
    logic [1:0]  p, q;
    logic [7:0]  a_pp, a_qq, a_pq;
    logic        pivot_valid, converged, busy;

    logic [31:0] r_mem [4];
    int          n_vec = 0;
    int          n_err = 0;

    pivot_selector #(.THRESH(8'd2), .READ_LAT(1)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .ena_cov(ena_cov), .addra_cov(addra_cov), .douta_cov(douta_cov),
        .p(p), .q(q), .a_pp(a_pp), .a_qq(a_qq), .a_pq(a_pq),
        .pivot_valid(pivot_valid), .converged(converged), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ena_cov) douta_cov <= r_mem[addra_cov];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] r0, r1, r2, r3);
        r_mem[0] = r0; r_mem[1] = r1; r_mem[2] = r2; r_mem[3] = r3;
    endtask

    // Caller is in cycle 0; returns in cycle 13 with FSM back in IDLE.
    task automatic run_op(input string tag, input logic [1:0] ep, eq,
                          input logic [7:0] epp, eqq, epq, input logic ec);
        logic [3:0] ctl;
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            start = 1'b0;
            ctl = {(c >= 1 && c <= 4), (c >= 1 && c <= 4) ? 2'(c - 1) : 2'd0, (c == 12)};
            check({tag, "_ctl"}, {28'd0, ena_cov, addra_cov, pivot_valid}, {28'd0, ctl});
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        end
        check({tag, "_res"}, {3'd0, p, q, a_pp, a_qq, a_pq, converged},
              {3'd0, ep, eq, epp, eqq, epq, ec});
        step();
        check({tag, "_idle"}, {30'd0, busy, pivot_valid}, 32'd0);
    endtask

    task automatic load_m1();
        load(32'h0A03F901, 32'h03140200, 32'hF9021E05, 32'h01000528);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        load(32'd0, 32'd0, 32'd0, 32'd0);
        step();
        check("reset_state", {15'd0, ena_cov, addra_cov, p, q, a_pp, pivot_valid, converged, busy},
              32'd0);
        rst = 1'b0;
        step();

`ifdef PIVOT_CYCLIC_EN
        load_m1();
        run_op("rr0", 2'd0, 2'd1, 8'h0A, 8'h14, 8'h03, 1'b0);
        run_op("rr1", 2'd0, 2'd2, 8'h0A, 8'h1E, 8'hF9, 1'b0);
        run_op("rr2", 2'd0, 2'd3, 8'h0A, 8'h28, 8'h01, 1'b0);
        run_op("rr3", 2'd1, 2'd2, 8'h14, 8'h1E, 8'h02, 1'b0);
        run_op("rr4", 2'd1, 2'd3, 8'h14, 8'h28, 8'h00, 1'b0);
        run_op("rr5", 2'd2, 2'd3, 8'h1E, 8'h28, 8'h05, 1'b0);
        run_op("rr6", 2'd0, 2'd1, 8'h0A, 8'h14, 8'h03, 1'b0);
        run_op("rr7", 2'd0, 2'd2, 8'h0A, 8'h1E, 8'hF9, 1'b0);
`else
        load_m1();
        run_op("m1", 2'd0, 2'd2, 8'h0A, 8'h1E, 8'hF9, 1'b0);
        load(32'h05010101, 32'h01060101, 32'h01010701, 32'h01010108);
        run_op("ones", 2'd0, 2'd1, 8'h05, 8'h06, 8'h01, 1'b1);
        load(32'h007F7F7F, 32'h7F007F80, 32'h7F7F007F, 32'h7F007F00);
        run_op("neg128", 2'd1, 2'd3, 8'h00, 8'h00, 8'h80, 1'b0);
        load(32'h00000000, 32'h00000000, 32'h000000FE, 32'h00000000);
        run_op("thresh_eq", 2'd2, 2'd3, 8'h00, 8'h00, 8'hFE, 1'b0);
        load(32'h01000000, 32'h00020000, 32'h00000300, 32'h00000004);
        run_op("all_zero", 2'd0, 2'd1, 8'h01, 8'h02, 8'h00, 1'b1);
        load_m1();
        run_op("m1_again", 2'd0, 2'd2, 8'h0A, 8'h1E, 8'hF9, 1'b0);
`endif

        // Abort mid-COMPARE: outputs clear at once, no pulse for the aborted op.
        load_m1();
        start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("abort_clear", {15'd0, ena_cov, addra_cov, p, q, a_pq, pivot_valid, converged, busy},
              32'd0);
        step();
        rst = 1'b0;
        begin
            logic seen_pv;
            seen_pv = 1'b0;
            for (int c = 0; c < 15; c++) begin
                step();
                seen_pv |= pivot_valid;
            end
            check("abort_no_pv", {31'd0, seen_pv}, 32'd0);
        end
`ifdef PIVOT_CYCLIC_EN
        run_op("after_rst", 2'd0, 2'd1, 8'h0A, 8'h14, 8'h03, 1'b0);
`else
        run_op("after_rst", 2'd0, 2'd2, 8'h0A, 8'h1E, 8'hF9, 1'b0);
`endif

        // Start held high: completions at cycles 12, 25 and 38 only.
        start = 1'b1;
        for (int c = 1; c <= 38; c++) begin
            step();
            check($sformatf("hold_pv_c%0d", c), {31'd0, pivot_valid},
                  {31'd0, (c == 12 || c == 25 || c == 38)});
        end
        start = 1'b0;
        step();
        step();
        check("hold_end_idle", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/pivot_selector.md
PIVOT_SELECTOR -- requirements
Module: pivot_selector

Interface
- REQ-001: Parameter THRESH, default 8'd2: unsigned convergence threshold on the pivot magnitude.
- REQ-002: Parameter READ_LAT, default 1: covariance BRAM read latency in cycles; only the value 1 is supported.
- REQ-003: clk  input  1  sole clock; all state updates on its rising edge.
- REQ-004: rst  input  1  reset, asynchronous and active-high.
- REQ-005: start  input  1  single-cycle request to select the next Jacobi pivot.
- REQ-006: ena_cov  output  1  covariance BRAM port enable (read only).
- REQ-007: addra_cov  output  2  covariance BRAM row address.
- REQ-008: douta_cov  input  32  row word; column 0 in [31:24] through column 3 in [7:0]; signed 8-bit elements.
- REQ-009: p, q  output  2 each  selected pivot indices, always with p < q.
- REQ-010: a_pp, a_qq, a_pq  output  8 each  signed elements A[p][p], A[q][q], A[p][q] of the selected pivot.
- REQ-011: pivot_valid  output  1  one-cycle pulse when p, q and a_* are updated.
- REQ-012: converged  output  1  updated with pivot_valid; 1 when the maximum off-diagonal magnitude is < THRESH.
- REQ-013: busy  output  1  high while an operation is in progress.

Function
- REQ-014: FSM states are IDLE, READ, CAPTURE, COMPARE and DONE.
- REQ-015: In IDLE, start=1 sampled at edge 0 moves the FSM to READ; start is ignored in every other state.
- REQ-016: In cycles 1-4, ena_cov=1 and addra_cov=0,1,2,3 (registered); ena_cov=0 at all other times.
- REQ-017: The row addressed in cycle k is captured from douta_cov at the end of cycle k+1 (cycles 2-5) into a 4x32 row register file.
- REQ-018: In COMPARE (cycles 6-11), one upper-triangle pair is evaluated per cycle, in the order (0,1),(0,2),(0,3),(1,2),(1,3),(2,3).
- REQ-019: Magnitude is the 8-bit unsigned absolute value, so |-128| = 128 without saturation.
- REQ-020: The running maximum updates only on strictly greater magnitude, so a tie keeps the earliest pair in the scan order.
- REQ-021: In DONE (cycle 12), pivot_valid=1 for exactly one cycle, and p, q, a_pp, a_qq, a_pq and converged are loaded.
- REQ-022: The FSM then returns to IDLE; a start in cycle 13 is accepted.
- REQ-023: busy=1 in cycles 1-12 inclusive.
- REQ-024: p, q, a_*, and converged hold their values until the next DONE.
- REQ-025: The lower triangle of the matrix is never used; the matrix is treated as symmetric.
- REQ-026: If all off-diagonal elements are zero, the selected pair is (0,1) and converged=1.

Reset
- REQ-027: rst=1 forces the FSM to IDLE asynchronously, from any state including mid-operation.
- REQ-028: During reset, ena_cov, addra_cov, p, q, a_*, pivot_valid, converged and busy are all 0, and the row file and maximum register are cleared.
- REQ-029: No pivot_valid pulse is produced for an operation aborted by reset.
- REQ-030: The cyclic index (see REQ-031) resets to pair (0,1).

Configuration
- REQ-031: With macro PIVOT_CYCLIC_EN defined, p and q come from a round-robin index that advances one step in the REQ-018 order per DONE and wraps from (2,3) to (0,1); a_* are taken for that pair.
- REQ-032: With PIVOT_CYCLIC_EN defined, converged is still computed from the maximum magnitude, and all timing is unchanged.
- REQ-033: Without PIVOT_CYCLIC_EN, the maximum-magnitude selection of REQ-018 to REQ-020 applies and no round-robin logic exists.

Verification
- REQ-034: Rows {10,3,-7,1},{3,20,2,0},{-7,2,30,5},{1,0,5,40}, start -> addra 0..3 on cycles 1-4; cycle 12 pivot_valid with p=0, q=2, a_pp=10, a_qq=30, a_pq=-7, converged=0.
- REQ-035: All off-diagonal elements 1, THRESH=2 -> p=0, q=1, converged=1 (tie rule and threshold).
- REQ-036: A[1][3]=-128, other off-diagonal elements 127 -> p=1, q=3, a_pq=8'h80.
- REQ-037: rst asserted in cycle 7 -> all outputs 0 immediately; no pivot_valid; a fresh start gives a normal result at +12 cycles.
- REQ-038: start held high continuously -> operations complete at cycles 12, 25, 38; starts in cycles 1-12 are ignored.
- REQ-039: PIVOT_CYCLIC_EN defined, 7 consecutive operations -> pairs (0,1),(0,2),(0,3),(1,2),(1,3),(2,3),(0,1).
